// File: rtl/serial_subtractor.sv
// serial_subtractor: computes Diff = A - B - Bin over WIDTH bits, STEP bits per clock, LSB first.
// Latency: start accepted at edge t0, busy for N = WIDTH/STEP cycles, done pulses for the cycle after edge t0+N.
// Backpressure: none; start is ignored while busy, and a start in the done cycle is accepted.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - operation request, sampled only when not busy
//   A, B, Bin       - minuend, subtrahend and borrow-in, captured when start is accepted
//   busy, done      - operation in progress / one-cycle result-valid pulse
//   Diff, Borr, Ovf - registered result, unsigned borrow-out and signed overflow

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr,
  output logic             Ovf
);

  // Reject parameter combinations that cannot tile the operand evenly.
  generate
    if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("serial_subtractor: STEP must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borr_q;
  logic             ovf_q;

  // Per-cycle slice: STEP bits of ripple borrow seeded from the borrow flop.
  logic [STEP-1:0]  slice_diff;
  logic [STEP:0]    chain;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    chain      = '0;
    slice_diff = '0;
    chain[0]   = borrow_q;
    for (int i = 0; i < STEP; i++) begin
      slice_diff[i] = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]    = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & chain[i]);
    end
    // Result bits enter at the top and move down, so after N cycles bit 0 sits at index 0.
    acc_d = (acc_q >> STEP) | (WIDTH'(slice_diff) << (WIDTH - STEP));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          a_q      <= a_q >> STEP;
          b_q      <= b_q >> STEP;
          acc_q    <= acc_d;
          borrow_q <= chain[STEP];
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // The top bit of this slice is the operand MSB, so its borrow-in/out give overflow.
            diff_q  <= acc_d;
            borr_q  <= chain[STEP];
            ovf_q   <= chain[STEP] ^ chain[STEP-1];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Borr = borr_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: eight instances (W1/S1, W8/S1, W8/S4, W16/S1..S16) share one clock and reset.
// Expected results are pushed to a scoreboard queue on launch and popped when the instance pulses done.
// Table-driven vectors plus hand-written handshake, back-to-back, ignored-start and reset sequences.

module tb_serial_subtractor;

  localparam int NI = 8;

  logic        clk;
  logic        rst;
  logic        start_s [NI];
  logic [15:0] a_s     [NI];
  logic [15:0] b_s     [NI];
  logic        bin_s   [NI];
  wire         busy_s  [NI];
  wire         done_s  [NI];
  wire  [15:0] diff_s  [NI];
  wire         borr_s  [NI];
  wire         ovf_s   [NI];

  wire  [0:0]  d_w1;
  wire  [7:0]  d_w8s1;
  wire  [7:0]  d_w8s4;

  int wid [NI] = '{1, 8, 8, 16, 16, 16, 16, 16};

  serial_subtractor #(.WIDTH(1), .STEP(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .A(a_s[0][0:0]), .B(b_s[0][0:0]), .Bin(bin_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .Diff(d_w1), .Borr(borr_s[0]), .Ovf(ovf_s[0]));
  assign diff_s[0] = {15'h0, d_w1};

  serial_subtractor #(.WIDTH(8), .STEP(1)) u_w8s1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .A(a_s[1][7:0]), .B(b_s[1][7:0]), .Bin(bin_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .Diff(d_w8s1), .Borr(borr_s[1]), .Ovf(ovf_s[1]));
  assign diff_s[1] = {8'h0, d_w8s1};

  serial_subtractor #(.WIDTH(8), .STEP(4)) u_w8s4 (
    .clk(clk), .rst(rst), .start(start_s[2]), .A(a_s[2][7:0]), .B(b_s[2][7:0]), .Bin(bin_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .Diff(d_w8s4), .Borr(borr_s[2]), .Ovf(ovf_s[2]));
  assign diff_s[2] = {8'h0, d_w8s4};

  for (genvar g = 0; g < 5; g++) begin : g16
    serial_subtractor #(.WIDTH(16), .STEP(1 << g)) u_w16 (
      .clk(clk), .rst(rst), .start(start_s[3+g]), .A(a_s[3+g]), .B(b_s[3+g]), .Bin(bin_s[3+g]),
      .busy(busy_s[3+g]), .done(done_s[3+g]), .Diff(diff_s[3+g]), .Borr(borr_s[3+g]), .Ovf(ovf_s[3+g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    int          k;
    int          seq;
    logic [15:0] diff;
    logic        borr;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   seq_no   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (done_s[k] === 1'b1) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done inst%0d: got done=1 expected no pulse", k);
        end else begin
          mon_e = sbq.pop_front();
          check($sformatf("sb_inst op%0d", mon_e.seq), 32'(k), 32'(mon_e.k));
          check($sformatf("diff op%0d inst%0d", mon_e.seq, k), 32'(diff_s[k]), 32'(mon_e.diff));
          check($sformatf("borr op%0d inst%0d", mon_e.seq, k), 32'(borr_s[k]), 32'(mon_e.borr));
          check($sformatf("ovf op%0d inst%0d", mon_e.seq, k), 32'(ovf_s[k]), 32'(mon_e.ovf));
        end
      end
    end
  end

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    longint m, half, ua, ub, sa, sb, r;
    logic [15:0] d;
    logic bo, ov;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    bo   = (ua < ub + longint'(bin));
    d    = 16'((ua - ub - longint'(bin)) & m);
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    r    = sa - sb - longint'(bin);
    ov   = (r < -half) || (r > half - 1);
    return {ov, bo, d};
  endfunction

  // Present operands with start for one edge, record the expectation, then scramble the inputs.
  task automatic launch(input int k, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic eo);
    exp_t e;
    @(negedge clk);
    a_s[k]     = a;
    b_s[k]     = b;
    bin_s[k]   = bin;
    start_s[k] = 1'b1;
    e.k = k; e.seq = seq_no; e.diff = ed; e.borr = eb; e.ovf = eo;
    seq_no++;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    start_s[k] = 1'b0;
    a_s[k]     = 16'($urandom);
    b_s[k]     = 16'($urandom);
    bin_s[k]   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got %0d results outstanding expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic eo);
    launch(k, a, b, bin, ed, eb, eo);
    wait_empty(40);
  endtask

  task automatic observe(input int k, input int win, output int bcnt, output int dat, output int dcnt);
    bcnt = 0; dat = 0; dcnt = 0;
    for (int i = 1; i <= win; i++) begin
      @(negedge clk);
      if (busy_s[k] === 1'b1) bcnt++;
      if (done_s[k] === 1'b1) begin
        dcnt++;
        if (dat == 0) dat = i;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        borr;
    logic        ovf;
  } vec_t;

  vec_t vt [14];

  initial begin
    int bc, da, dc, nw;
    logic seen;
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic rbin;
    int rk;

    vt[0]  = '{0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[1]  = '{0, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b1};
    vt[2]  = '{0, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0};
    vt[3]  = '{0, 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[4]  = '{1, 16'h005A, 16'h003C, 1'b0, 16'h001E, 1'b0, 1'b0};
    vt[5]  = '{1, 16'h0010, 16'h0020, 1'b0, 16'h00F0, 1'b1, 1'b0};
    vt[6]  = '{1, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b1};
    vt[7]  = '{1, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vt[8]  = '{1, 16'h00FF, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vt[9]  = '{1, 16'h007F, 16'h00FF, 1'b0, 16'h0080, 1'b1, 1'b1};
    vt[10] = '{2, 16'h00A5, 16'h005A, 1'b0, 16'h004B, 1'b0, 1'b1};
    vt[11] = '{2, 16'h0010, 16'h0020, 1'b0, 16'h00F0, 1'b1, 1'b0};
    vt[12] = '{2, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b1};
    vt[13] = '{2, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 1'b1, 1'b0};

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0;
      a_s[k]     = 16'h0;
      b_s[k]     = 16'h0;
      bin_s[k]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++)
      check($sformatf("reset_outputs inst%0d", k),
            32'({busy_s[k], done_s[k], borr_s[k], ovf_s[k], diff_s[k]}), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table vectors with hand-derived expectations.
    for (int i = 0; i < 14; i++)
      run_op(vt[i].k, vt[i].a, vt[i].b, vt[i].bin, vt[i].diff, vt[i].borr, vt[i].ovf);

    // W8/S1 handshake timing: busy 8 cycles, done single pulse in the 9th cycle after acceptance.
    launch(1, 16'h005A, 16'h003C, 1'b0, 16'h001E, 1'b0, 1'b0);
    observe(1, 12, bc, da, dc);
    check("w8s1_busy_cycles", 32'(bc), 32'd8);
    check("w8s1_done_at", 32'(da), 32'd9);
    check("w8s1_done_count", 32'(dc), 32'd1);
    wait_empty(40);

    // N=1 instances: one RUN cycle, done in the following cycle.
    launch(0, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b1);
    observe(0, 5, bc, da, dc);
    check("w1_busy_cycles", 32'(bc), 32'd1);
    check("w1_done_at", 32'(da), 32'd2);
    wait_empty(40);
    m = model(16, 16'h1234, 16'h4321, 1'b1);
    launch(7, 16'h1234, 16'h4321, 1'b1, m[15:0], m[16], m[17]);
    observe(7, 5, bc, da, dc);
    check("w16s16_busy_cycles", 32'(bc), 32'd1);
    check("w16s16_done_at", 32'(da), 32'd2);
    wait_empty(40);

    // W8/S4 back-to-back: start in the done cycle is accepted, next result N+1 cycles later.
    launch(2, 16'h00A5, 16'h005A, 1'b0, 16'h004B, 1'b0, 1'b1);
    seen = 1'b0;
    nw = 0;
    while (!seen && nw < 10) begin
      @(negedge clk);
      nw++;
      if (done_s[2] === 1'b1) seen = 1'b1;
    end
    check("b2b_first_done_seen", 32'(seen), 32'd1);
    a_s[2] = 16'h0033; b_s[2] = 16'h0044; bin_s[2] = 1'b0; start_s[2] = 1'b1;
    sbq.push_back('{2, seq_no, 16'h00EF, 1'b1, 1'b0});
    seq_no++;
    @(posedge clk);
    #1;
    start_s[2] = 1'b0;
    observe(2, 6, bc, da, dc);
    check("b2b_busy_cycles", 32'(bc), 32'd2);
    check("b2b_done_at", 32'(da), 32'd3);
    check("b2b_done_count", 32'(dc), 32'd1);
    wait_empty(40);

    // Start pulsed mid-RUN with other operands must be ignored.
    launch(1, 16'h005A, 16'h003C, 1'b0, 16'h001E, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    a_s[1] = 16'h00FF; b_s[1] = 16'h0001; start_s[1] = 1'b1;
    @(posedge clk);
    #1;
    start_s[1] = 1'b0;
    wait_empty(40);
    observe(1, 12, bc, da, dc);
    check("ignored_start_no_extra_done", 32'(dc), 32'd0);

    // Reset in RUN cycle 3: outputs clear without a clock edge, no done, clean restart.
    run_op(1, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b1);
    launch(1, 16'h0012, 16'h0034, 1'b0, 16'h00DE, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_precond_busy", 32'(busy_s[1]), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_clear", 32'({busy_s[1], done_s[1], borr_s[1], ovf_s[1], diff_s[1]}), 32'h0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    observe(1, 20, bc, da, dc);
    check("rst_no_done", 32'(dc), 32'd0);
    check("rst_idle_after", 32'(bc), 32'd0);
    run_op(1, 16'h0033, 16'h0011, 1'b0, 16'h0022, 1'b0, 1'b0);

    // Randomised operations on the W16 instances against the integer model.
    for (int i = 0; i < 1000; i++) begin
      rk   = 3 + (i % 5);
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if (i % 50 == 0) rb = ra;
      m = model(wid[rk], ra, rb, rbin);
      run_op(rk, ra, rb, rbin, m[15:0], m[16], m[17]);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
